// File: rtl/intdiv_seq.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Signed mode divides magnitudes and fixes signs on the final iteration (truncating semantics).
module intdiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;

   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;

   assign dvd_neg = is_signed & dividend[WIDTH-1];
   assign dvs_neg = is_signed & divisor[WIDTH-1];
   assign dvd_mag = dvd_neg ? -dividend : dividend;
   assign dvs_mag = dvs_neg ? -divisor : divisor;

   // The partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
   // and the sign of the WIDTH+1-bit trial difference decides the quotient bit.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvs_q};
   assign rem_d  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     dbz_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     dvs_q     <= dvs_mag;
                     quo_q     <= dvd_mag;
                     rem_q     <= '0;
                     count_q   <= CW'(WIDTH);
                     neg_quo_q <= dvd_neg ^ dvs_neg;
                     neg_rem_q <= dvd_neg;
                     state_q   <= RUN;
                  end
               end
            end
            RUN: begin
               rem_q   <= rem_d;
               quo_q   <= quo_d;
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  quotient_q  <= neg_quo_q ? -quo_d : quo_d;
                  remainder_q <= neg_rem_q ? -rem_d : rem_d;
                  dbz_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_intdiv_seq.sv
// Directed and randomized checks of intdiv_seq against a plain-arithmetic division model.
module tb_intdiv_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         is_signed;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   intdiv_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .is_signed  (is_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division done with 64-bit host arithmetic.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else if (s) begin
         q = W'(sa / sb);
         r = W'(sa % sb);
         z = 1'b0;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int stall, input bit toggle);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ez;
      int           lat;
      model(a, b, s, eq, er, ez);
      dividend  = a;
      divisor   = b;
      is_signed = s;
      in_valid  = 1'b1;
      chk("in_ready_idle", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         chk("in_ready_busy", 64'(in_ready), 64'd0);
         if (toggle) begin
            dividend  = $urandom;
            divisor   = $urandom;
            is_signed = ~is_signed;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      // Divide-by-zero results are already visible in the cycle right after the accept edge.
      chk("latency", 64'(lat), (b == '0) ? 64'd0 : 64'(W));
      chk("quotient", 64'(quotient), 64'(eq));
      chk("remainder", 64'(remainder), 64'(er));
      chk("div_by_zero", 64'(div_by_zero), 64'(ez));
      chk("in_ready_done", 64'(in_ready), 64'd0);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_quotient", 64'(quotient), 64'(eq));
         chk("stall_remainder", 64'(remainder), 64'(er));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_drop", 64'(out_valid), 64'd0);
      chk("in_ready_back", 64'(in_ready), 64'd1);
      chk("hold_quotient", 64'(quotient), 64'(eq));
      $display("div %h / %h signed=%0d -> q=%h r=%h dbz=%0d lat=%0d", a, b, s,
               quotient, remainder, div_by_zero, lat);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      is_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_quotient", 64'(quotient), 64'd0);
      chk("rst_remainder", 64'(remainder), 64'd0);
      chk("rst_dbz", 64'(div_by_zero), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      run_op(32'h8000_0000, 32'd0, 1'b1, 2, 1'b0);
      run_op(32'd1234567, 32'd89, 1'b0, 10, 1'b1);

      // Abort an operation 15 cycles into RUN.
      dividend = 32'd1000;
      divisor  = 32'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_quotient", 64'(quotient), 64'd0);
      chk("abort_remainder", 64'(remainder), 64'd0);
      chk("abort_dbz", 64'(div_by_zero), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("abort_no_valid", 64'(seen), 64'd0);
      chk("abort_in_ready_after", 64'(in_ready), 64'd1);
      run_op(32'd12, 32'd4, 1'b0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = W'($urandom_range(1, 15));
            2:       rb = -W'($urandom_range(1, 15));
            default: rb = (i % 10 == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'(i % 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
